// File: rtl/audio_sample_scheduler.sv
// Paces a valid/ready sample source at the audio rate: one src_ready window per DIV-cycle period,
// registered sample output with strobe, underrun detection and mute. Optional: AUDIO_SCHED_UNDERRUN_CNT_EN.
module audio_sample_scheduler #(
    parameter int DATA_W  = 24,
    parameter int DIV     = 1134,
    parameter int TIMEOUT = 16
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              enable,
    input  logic              mute,
    input  logic              src_valid,
    input  logic [DATA_W-1:0] src_data,
    output logic              src_ready,
    output logic [DATA_W-1:0] sample_out,
    output logic              sample_strobe,
    output logic              underrun,
    output logic [15:0]       underrun_count,
    input  logic              cnt_clear
);

    localparam int TICK_W = $clog2(DIV);
    localparam int WAIT_W = $clog2(TIMEOUT + 1);

    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_FETCH} state_e;

    state_e              state_q, state_d;
    logic [TICK_W-1:0]   tick_cnt_q, tick_cnt_d;
    logic [WAIT_W-1:0]   wait_q, wait_d;
    logic                src_ready_q, src_ready_d;
    logic [DATA_W-1:0]   sample_q, sample_d;
    logic                strobe_q, strobe_d;
    logic                underrun_q, underrun_d;

    logic tick;
    logic handshake;
    logic timeout;

    assign tick      = (tick_cnt_q == TICK_W'(DIV - 1));
    assign handshake = (state_q == S_FETCH) && src_ready_q && src_valid;
    assign timeout   = (state_q == S_FETCH) && !handshake && (wait_q == WAIT_W'(TIMEOUT - 1));

    // The period counter only runs once the FSM has left IDLE, so the first tick lands DIV cycles after enable.
    always_comb begin
        tick_cnt_d = '0;
        if (enable && state_q != S_IDLE)
            tick_cnt_d = tick ? '0 : tick_cnt_q + TICK_W'(1);
    end

    // NOTE: every always_comb output gets a default first so no path can leave it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            S_IDLE:  if (enable) state_d = S_WAIT;
            S_WAIT:  if (!enable) state_d = S_IDLE;
                     else if (tick) state_d = S_WAIT == S_WAIT ? S_FETCH : S_WAIT;
            S_FETCH: if (handshake) state_d = enable ? S_WAIT : S_IDLE;
                     else if (!enable) state_d = S_IDLE;
                     else if (timeout) state_d = S_WAIT;
            default: state_d = S_IDLE;
        endcase
    end

    // A completed handshake wins over a concurrent disable; an expiring wait does not.
    always_comb begin
        src_ready_d = (state_d == S_FETCH);
        wait_d      = (state_q == S_FETCH && state_d == S_FETCH) ? wait_q + WAIT_W'(1) : '0;
        sample_d    = sample_q;
        strobe_d    = 1'b0;
        underrun_d  = 1'b0;
        if (handshake) begin
            sample_d = mute ? '0 : src_data;
            strobe_d = 1'b1;
        end else if (timeout && enable) begin
            if (mute) sample_d = '0;
            strobe_d   = 1'b1;
            underrun_d = 1'b1;
        end
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= S_IDLE;
            tick_cnt_q  <= '0;
            wait_q      <= '0;
            src_ready_q <= 1'b0;
            sample_q    <= '0;
            strobe_q    <= 1'b0;
            underrun_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_cnt_q  <= tick_cnt_d;
            wait_q      <= wait_d;
            src_ready_q <= src_ready_d;
            sample_q    <= sample_d;
            strobe_q    <= strobe_d;
            underrun_q  <= underrun_d;
        end
    end

    assign src_ready     = src_ready_q;
    assign sample_out    = sample_q;
    assign sample_strobe = strobe_q;
    assign underrun      = underrun_q;

`ifdef AUDIO_SCHED_UNDERRUN_CNT_EN
    logic [15:0] cnt_q, cnt_d;

    // Counts visible underrun pulses; a clear in the pulse cycle takes precedence.
    always_comb begin
        cnt_d = cnt_q;
        if (cnt_clear)
            cnt_d = '0;
        else if (underrun_q && cnt_q != 16'hFFFF)
            cnt_d = cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) cnt_q <= '0;
        else          cnt_q <= cnt_d;
    end

    assign underrun_count = cnt_q;
`else
    logic unused_cnt_clear;
    assign unused_cnt_clear = cnt_clear;
    assign underrun_count   = '0;
`endif

endmodule
